// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the 5-stage MIPS core pipeline registers.
//   DATA_W / REG_AW / CNT_W : datapath, register-index and ALU-control widths
//   fwd_sel_t               : which source an operand forward came from
//   id_ex_ctrl_t            : control bits carried from ID into EX
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } id_ex_ctrl_t;

    // A bubble carries no side effects: nothing written, nothing loaded or stored.
    localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Operand forwarding selector for one source register held in ID/EX.
// Ports:
//   reg_idx         : register index of the operand held in EX
//   reg_val         : value captured for that register at ID/EX
//   exmem_*         : EX/MEM write-back intent, destination and ALU result
//   memwb_*         : MEM/WB write-back intent, destination and data
//   data            : operand value after forwarding
//   sel             : which source supplied data
// ---------------------------------------------------------------------------
module fwd_mux
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] reg_idx,
    input  logic [DATA_W-1:0] reg_val,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [DATA_W-1:0] data,
    output fwd_sel_t          sel
);

    // The younger result (EX/MEM) wins over the older one (MEM/WB), and
    // register 0 is hard-wired to zero so it is never forwarded.
    always_comb begin
        sel  = FWD_NONE;
        data = reg_val;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == reg_idx)) begin
            sel  = FWD_EXMEM;
            data = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == reg_idx)) begin
            sel  = FWD_MEMWB;
            data = memwb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register feeding the ALU, with RAW hazard handling.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   id_*                   : decoded instruction fields and control from ID
//   flush                  : branch taken in EX, squash the ID instruction
//   exmem_*, memwb_*       : forwarding sources from later stages
//   stall                  : hold PC and IF/ID (load-use hazard)
//   ex_valid               : EX holds a real instruction
//   alu_in1/alu_in2/alu_cnt/alu_shamt : ALU operand and control ports
//   ex_store_data          : forwarded rt value for stores
//   ex_dest                : selected destination register
//   ex_reg_write/ex_mem_read/ex_mem_write/ex_mem_to_reg : registered control
// ---------------------------------------------------------------------------
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW,
    parameter int CNT_W  = mips_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [CNT_W-1:0]  id_alu_cnt,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [CNT_W-1:0]  alu_cnt,
    output logic [4:0]        alu_shamt,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg
);

    id_ex_ctrl_t       ctrl_q;
    logic              valid_q;
    logic              alu_src_q;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic [REG_AW-1:0] dest_q;
    logic [DATA_W-1:0] rs_val_q;
    logic [DATA_W-1:0] rt_val_q;
    logic [DATA_W-1:0] imm_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [4:0]        shamt_q;

    logic              uses_rt;
    logic [DATA_W-1:0] rs_cap;
    logic [DATA_W-1:0] rt_cap;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    fwd_sel_t          rs_sel;
    fwd_sel_t          rt_sel;

    // Immediate-form ALU ops ignore rt unless the instruction is a store,
    // which needs rt as its store data.
    assign uses_rt = !id_alu_src || id_mem_write;

    // Load-use: the loaded value is not available until after MEM, so the
    // dependent instruction waits one cycle. A flush squashes it anyway.
    assign stall = id_valid && valid_q && ctrl_q.mem_read && (dest_q != '0)
                   && ((dest_q == id_rs) || (uses_rt && (dest_q == id_rt)))
                   && !flush;

    // The regfile write in WB happens on the same edge as this capture, so
    // the read in ID may be stale; take the WB data directly in that case.
    always_comb begin
        rs_cap = id_rs_data;
        rt_cap = id_rt_data;
        if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs)) begin
            rs_cap = memwb_data;
        end
        if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rt)) begin
            rt_cap = memwb_data;
        end
    end

    // Pipeline register. Data fields always follow ID outside reset; only
    // valid and the control bits need to be cleared to form a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= CTRL_BUBBLE;
            alu_src_q <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            dest_q    <= '0;
            rs_val_q  <= '0;
            rt_val_q  <= '0;
            imm_q     <= '0;
            cnt_q     <= '0;
            shamt_q   <= '0;
        end else begin
            alu_src_q <= id_alu_src;
            rs_q      <= id_rs;
            rt_q      <= id_rt;
            dest_q    <= id_reg_dst ? id_rd : id_rt;
            rs_val_q  <= rs_cap;
            rt_val_q  <= rt_cap;
            imm_q     <= id_imm;
            cnt_q     <= id_alu_cnt;
            shamt_q   <= id_shamt;
            if (flush || stall) begin
                valid_q <= 1'b0;
                ctrl_q  <= CTRL_BUBBLE;
            end else begin
                valid_q           <= id_valid;
                ctrl_q.reg_write  <= id_reg_write;
                ctrl_q.mem_read   <= id_mem_read;
                ctrl_q.mem_write  <= id_mem_write;
                ctrl_q.mem_to_reg <= id_mem_to_reg;
            end
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .reg_idx         (rs_q),
        .reg_val         (rs_val_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_data      (memwb_data),
        .data            (rs_fwd),
        .sel             (rs_sel)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .reg_idx         (rt_q),
        .reg_val         (rt_val_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_data      (memwb_data),
        .data            (rt_fwd),
        .sel             (rt_sel)
    );

    // When nothing is forwarded, take the registered copy straight from the
    // pipeline register rather than through the mux data path.
    assign alu_in1       = (rs_sel == FWD_NONE) ? rs_val_q : rs_fwd;
    assign ex_store_data = (rt_sel == FWD_NONE) ? rt_val_q : rt_fwd;
    assign alu_in2       = alu_src_q ? imm_q : ex_store_data;

    assign ex_valid      = valid_q;
    assign alu_cnt       = cnt_q;
    assign alu_shamt     = shamt_q;
    assign ex_dest       = dest_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage: reset, capture, forwarding, load-use stall,
// flush, and WB capture bypass, with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt;
    logic [3:0]  id_alu_cnt;
    logic        id_alu_src, id_reg_dst;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        flush;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic        stall, ex_valid;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [3:0]  alu_cnt;
    logic [4:0]  alu_shamt;
    logic [4:0]  ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    int errors = 0;
    int checks = 0;

    id_ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_imm          (id_imm),
        .id_shamt        (id_shamt),
        .id_alu_cnt      (id_alu_cnt),
        .id_alu_src      (id_alu_src),
        .id_reg_dst      (id_reg_dst),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .id_mem_to_reg   (id_mem_to_reg),
        .flush           (flush),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_data      (memwb_data),
        .stall           (stall),
        .ex_valid        (ex_valid),
        .alu_in1         (alu_in1),
        .alu_in2         (alu_in2),
        .alu_cnt         (alu_cnt),
        .alu_shamt       (alu_shamt),
        .ex_store_data   (ex_store_data),
        .ex_dest         (ex_dest),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_mem_to_reg   (ex_mem_to_reg)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and on mismatch count the failure and report.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Idle ID and forwarding inputs.
    task automatic clearInputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0; id_alu_cnt = 0;
        id_alu_src = 0; id_reg_dst = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        flush = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    // R-type: rd = rs op rt.
    task automatic setRtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [31:0] rsd, input logic [31:0] rtd, input logic [3:0] cnt);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = 32'h0; id_shamt = 5'd0; id_alu_cnt = cnt;
        id_alu_src = 0; id_reg_dst = 1;
        id_reg_write = 1; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    endtask

    // lw rt, imm(rs).
    task automatic setLoad(input logic [4:0] rs, input logic [4:0] rt,
                           input logic [31:0] rsd, input logic [31:0] imm);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = 5'd0;
        id_rs_data = rsd; id_rt_data = 32'h0; id_imm = imm; id_shamt = 5'd0; id_alu_cnt = 4'd2;
        id_alu_src = 1; id_reg_dst = 0;
        id_reg_write = 1; id_mem_read = 1; id_mem_write = 0; id_mem_to_reg = 1;
    endtask

    initial begin
        clearInputs();

        // Reset held two cycles while ID presents a real instruction.
        rst = 1;
        setRtype(5'd1, 5'd2, 5'd3, 32'd9, 32'd11, 4'd2);
        id_shamt = 5'd7;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_ex_valid", 32'(ex_valid), 32'd0);
        checkOutput("rst_reg_write", 32'(ex_reg_write), 32'd0);
        checkOutput("rst_mem_to_reg", 32'(ex_mem_to_reg), 32'd0);
        checkOutput("rst_alu_in1", alu_in1, 32'd0);
        checkOutput("rst_alu_in2", alu_in2, 32'd0);
        checkOutput("rst_store", ex_store_data, 32'd0);
        checkOutput("rst_alu_cnt", 32'(alu_cnt), 32'd0);
        checkOutput("rst_shamt", 32'(alu_shamt), 32'd0);
        checkOutput("rst_dest", 32'(ex_dest), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);

        // add r3 = r1 + r2 captured on the first edge after release.
        rst = 0;
        setRtype(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 4'd2);
        applyStimulus();
        checkOutput("add_valid", 32'(ex_valid), 32'd1);
        checkOutput("add_in1", alu_in1, 32'd5);
        checkOutput("add_in2", alu_in2, 32'd7);
        checkOutput("add_dest", 32'(ex_dest), 32'd3);
        checkOutput("add_reg_write", 32'(ex_reg_write), 32'd1);
        checkOutput("add_alu_cnt", 32'(alu_cnt), 32'd2);

        // Forwarding onto the held add (rs=1, rt=2).
        id_valid = 0;
        exmem_reg_write = 1; exmem_rd = 5'd1; exmem_result = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 5'd1; memwb_data = 32'hBB;
        #1;
        checkOutput("fwd_exmem_wins", alu_in1, 32'hAA);
        exmem_reg_write = 0;
        #1;
        checkOutput("fwd_memwb", alu_in1, 32'hBB);
        exmem_reg_write = 1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        #1;
        checkOutput("fwd_r0_none", alu_in1, 32'd5);
        exmem_rd = 5'd2; exmem_result = 32'hCC;
        #1;
        checkOutput("fwd_rt_in2", alu_in2, 32'hCC);
        checkOutput("fwd_rt_store", ex_store_data, 32'hCC);
        exmem_reg_write = 0; memwb_reg_write = 0;

        // Load-use: lw r4 in EX, add r5 = r4 + r2 in ID.
        setLoad(5'd1, 5'd4, 32'h100, 32'd8);
        applyStimulus();
        checkOutput("lw_mem_read", 32'(ex_mem_read), 32'd1);
        checkOutput("lw_dest", 32'(ex_dest), 32'd4);
        checkOutput("lw_in1", alu_in1, 32'h100);
        checkOutput("lw_in2_imm", alu_in2, 32'd8);
        setRtype(5'd4, 5'd2, 5'd5, 32'h0, 32'd3, 4'd2);
        #1;
        checkOutput("lu_stall", 32'(stall), 32'd1);
        applyStimulus();
        checkOutput("lu_bubble_valid", 32'(ex_valid), 32'd0);
        checkOutput("lu_bubble_reg_write", 32'(ex_reg_write), 32'd0);
        checkOutput("lu_bubble_mem_read", 32'(ex_mem_read), 32'd0);
        checkOutput("lu_stall_released", 32'(stall), 32'd0);
        applyStimulus();
        memwb_reg_write = 1; memwb_rd = 5'd4; memwb_data = 32'h123;
        #1;
        checkOutput("lu_retry_valid", 32'(ex_valid), 32'd1);
        checkOutput("lu_retry_fwd", alu_in1, 32'h123);
        checkOutput("lu_retry_dest", 32'(ex_dest), 32'd5);
        memwb_reg_write = 0;

        // Same load-use with flush: no stall, next EX is a bubble.
        setLoad(5'd1, 5'd4, 32'h100, 32'd8);
        applyStimulus();
        setRtype(5'd4, 5'd2, 5'd5, 32'h0, 32'd3, 4'd2);
        flush = 1;
        #1;
        checkOutput("flush_no_stall", 32'(stall), 32'd0);
        applyStimulus();
        checkOutput("flush_bubble_valid", 32'(ex_valid), 32'd0);
        checkOutput("flush_bubble_reg_write", 32'(ex_reg_write), 32'd0);
        flush = 0;

        // addi r4 = r1 + imm behind lw r4: rt not used, no stall; sw would stall.
        setLoad(5'd1, 5'd4, 32'h100, 32'd8);
        applyStimulus();
        id_rs = 5'd1; id_rt = 5'd4; id_alu_src = 1; id_reg_dst = 0;
        id_mem_read = 0; id_mem_write = 1; id_mem_to_reg = 0; id_reg_write = 0;
        #1;
        checkOutput("sw_uses_rt_stall", 32'(stall), 32'd1);
        id_mem_write = 0; id_reg_write = 1; id_imm = 32'd16;
        #1;
        checkOutput("addi_no_stall", 32'(stall), 32'd0);
        applyStimulus();
        checkOutput("addi_valid", 32'(ex_valid), 32'd1);
        checkOutput("addi_dest_rt", 32'(ex_dest), 32'd4);
        checkOutput("addi_in2_imm", alu_in2, 32'd16);

        // Capture bypass: WB writes r2 while sw reads stale r2 in ID.
        id_valid = 1; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd0;
        id_rs_data = 32'h40; id_rt_data = 32'h11; id_imm = 32'd4;
        id_alu_src = 1; id_reg_dst = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 1; id_mem_to_reg = 0;
        memwb_reg_write = 1; memwb_rd = 5'd2; memwb_data = 32'h55;
        applyStimulus();
        memwb_reg_write = 0;
        #1;
        checkOutput("bypass_store", ex_store_data, 32'h55);
        checkOutput("bypass_mem_write", 32'(ex_mem_write), 32'd1);

        // Mid-stream reset drops a pending load-use stall.
        setLoad(5'd1, 5'd6, 32'h100, 32'd8);
        applyStimulus();
        setRtype(5'd6, 5'd2, 5'd7, 32'h0, 32'd3, 4'd2);
        rst = 1;
        applyStimulus();
        checkOutput("midrst_valid", 32'(ex_valid), 32'd0);
        checkOutput("midrst_stall", 32'(stall), 32'd0);
        checkOutput("midrst_dest", 32'(ex_dest), 32'd0);
        rst = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
